// File: rtl/vend_ctrl.sv
// Vending machine sequencing controller: accumulates coin credit, runs the
// purchase/refund flow, handshakes with the dispenser and pays change in 5-cent units.
module vend_ctrl #(
  parameter int PRICE        = 75,
  parameter int MAX_CREDIT   = 200,
  parameter int CREDIT_W     = 8,
  parameter int DISP_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic [1:0]          coin_val,
  input  logic                select,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                fault,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCEPT   = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_t;

  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(5);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [TW-1:0]       TMO_LAST = TW'(DISP_TIMEOUT - 1);

  state_t              st;
  logic [TW-1:0]       wait_cnt;
  logic [CREDIT_W-1:0] coin_cents;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;

  always_comb begin
    coin_cents = '0;
    case (coin_val)
      2'b00:   coin_cents = CREDIT_W'(5);
      2'b01:   coin_cents = CREDIT_W'(10);
      2'b10:   coin_cents = CREDIT_W'(25);
      default: coin_cents = '0;
    endcase
    // One extra bit so a sum past the ceiling cannot wrap back under it
    coin_sum = {1'b0, credit} + {1'b0, coin_cents};
    coin_ok  = coin && (coin_val != 2'b11) && (coin_sum <= MAX_C);
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= IDLE;
      credit       <= '0;
      disp_req     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      fault        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      // Any coin is refused unless a branch below explicitly takes it
      coin_reject  <= coin;
      change_pulse <= 1'b0;
      fault        <= 1'b0;
      disp_req     <= 1'b0;
      case (st)
        IDLE: begin
          if (coin_ok) begin
            credit      <= coin_sum[CREDIT_W-1:0];
            coin_reject <= 1'b0;
            st          <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (cancel) begin
            st <= CHANGE;
          end else if (select) begin
            st <= CHECK;
          end else if (coin_ok) begin
            credit      <= coin_sum[CREDIT_W-1:0];
            coin_reject <= 1'b0;
          end
        end
        CHECK: begin
          if (credit >= PRICE_C) begin
            credit   <= credit - PRICE_C;
            disp_req <= 1'b1;
            st       <= DISPENSE;
          end else begin
            st <= ACCEPT;
          end
        end
        DISPENSE: begin
          if (disp_ack) begin
            wait_cnt <= '0;
            st       <= (credit != '0) ? CHANGE : IDLE;
          end else if (wait_cnt == TMO_LAST) begin
            // Dispenser never answered: give the price back and refund everything
            wait_cnt <= '0;
            credit   <= credit + PRICE_C;
            fault    <= 1'b1;
            st       <= CHANGE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            disp_req <= 1'b1;
          end
        end
        CHANGE: begin
          if (credit >= UNIT_C) begin
            change_pulse <= 1'b1;
            credit       <= credit - UNIT_C;
          end else begin
            st <= IDLE;
          end
        end
        default: begin
          st       <= IDLE;
          credit   <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl: directed purchase/refund/timeout/reset scenarios,
// a cycle-level behavioural model compared every cycle, plus literal spot checks.
module tb_vend_ctrl;

  localparam int PRICE = 75;
  localparam int MAXC  = 200;
  localparam int TMO   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       select = 1'b0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req, change_pulse, coin_reject, fault;
  logic [7:0] credit;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(8), .DISP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .coin(coin), .coin_val(coin_val), .select(select),
    .cancel(cancel), .disp_ack(disp_ack), .disp_req(disp_req),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .fault(fault),
    .credit(credit), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, one update per rising edge
  int m_state = 0, m_credit = 0, m_dwell = 0;
  bit m_req = 0, m_pulse = 0, m_reject = 0, m_fault = 0, started = 0;

  function automatic int cents(input logic [1:0] v);
    return (v == 2'b00) ? 5 : (v == 2'b01) ? 10 : (v == 2'b10) ? 25 : 0;
  endfunction

  always @(posedge clk) begin
    bit take;
    m_pulse = 0; m_fault = 0; m_reject = 0;
    if (!rst) begin
      m_state = 0; m_credit = 0; m_dwell = 0; m_req = 0; started = 1;
    end else begin
      take = coin && coin_val != 2'b11 && (m_credit + cents(coin_val) <= MAXC)
             && (m_state == 0 || (m_state == 1 && !cancel && !select));
      if (take) begin
        m_credit += cents(coin_val);
        m_state = 1;
      end else begin
        m_reject = coin;
        if (m_state == 1 && cancel) m_state = 4;
        else if (m_state == 1 && select) m_state = 2;
        else if (m_state == 2) begin
          if (m_credit >= PRICE) begin m_credit -= PRICE; m_state = 3; end
          else m_state = 1;
        end else if (m_state == 3) begin
          if (disp_ack) begin
            m_dwell = 0;
            m_state = (m_credit > 0) ? 4 : 0;
          end else begin
            m_dwell++;
            if (m_dwell == TMO) begin
              m_dwell = 0; m_credit += PRICE; m_fault = 1; m_state = 4;
            end
          end
        end else if (m_state == 4) begin
          if (m_credit >= 5) begin m_pulse = 1; m_credit -= 5; end
          else m_state = 0;
        end
      end
      m_req = (m_state == 3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model.state", 32'(state), 32'(m_state));
      chk("model.credit", 32'(credit), 32'(m_credit));
      chk("model.disp_req", 32'(disp_req), 32'(m_req));
      chk("model.change_pulse", 32'(change_pulse), 32'(m_pulse));
      chk("model.coin_reject", 32'(coin_reject), 32'(m_reject));
      chk("model.fault", 32'(fault), 32'(m_fault));
    end
  end

  // Drive one cycle of inputs; returns at the next falling edge with results visible
  task automatic cyc(input bit c, input logic [1:0] cv, input bit s, input bit ca, input bit a);
    coin = c; coin_val = cv; select = s; cancel = ca; disp_ack = a;
    @(negedge clk);
    coin = 0; coin_val = 2'b00; select = 0; cancel = 0; disp_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      idle(1);
      if (change_pulse === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n3;
    @(negedge clk);
    // 1: reset, exact payment, delayed ack
    rst = 0; idle(2);
    chk("reset.state", 32'(state), 0);
    chk("reset.credit", 32'(credit), 0);
    rst = 1;
    repeat (3) cyc(1, 2'b10, 0, 0, 0);
    $display("[TB] exact pay: credit=%0d state=%0d", credit, state);
    chk("exact.credit", 32'(credit), 75);
    chk("exact.state", 32'(state), 1);
    cyc(0, 2'b00, 1, 0, 0);
    chk("exact.check", 32'(state), 2);
    idle(1);
    chk("exact.dispense", 32'(state), 3);
    chk("exact.credit0", 32'(credit), 0);
    chk("exact.req", 32'(disp_req), 1);
    idle(2);
    cyc(0, 2'b00, 0, 0, 1);
    chk("exact.ack_req", 32'(disp_req), 0);
    chk("exact.ack_state", 32'(state), 0);
    count_pulses(4, n);
    chk("exact.no_change", 32'(n), 0);

    // 2: overpay by 25
    repeat (4) cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    idle(1);
    chk("overpay.credit", 32'(credit), 25);
    cyc(0, 2'b00, 0, 0, 1);
    count_pulses(8, n);
    $display("[TB] overpay: pulses=%0d state=%0d", n, state);
    chk("overpay.pulses", 32'(n), 5);
    chk("overpay.credit0", 32'(credit), 0);
    chk("overpay.state", 32'(state), 0);

    // 3: short credit, cancel, invalid coin
    cyc(1, 2'b01, 0, 0, 0);
    cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    chk("short.check", 32'(state), 2);
    idle(1);
    chk("short.back", 32'(state), 1);
    chk("short.credit", 32'(credit), 35);
    cyc(0, 2'b00, 0, 1, 0);
    chk("cancel.state", 32'(state), 4);
    count_pulses(10, n);
    $display("[TB] cancel: pulses=%0d state=%0d", n, state);
    chk("cancel.pulses", 32'(n), 7);
    chk("cancel.state_idle", 32'(state), 0);
    cyc(1, 2'b11, 0, 0, 0);
    chk("invalid.reject", 32'(coin_reject), 1);
    chk("invalid.credit", 32'(credit), 0);
    chk("invalid.state", 32'(state), 0);
    idle(1);
    chk("invalid.one_cycle", 32'(coin_reject), 0);

    // 4: credit ceiling, coin colliding with select
    repeat (8) cyc(1, 2'b10, 0, 0, 0);
    chk("ceil.credit", 32'(credit), 200);
    cyc(1, 2'b00, 0, 0, 0);
    $display("[TB] ceiling: reject=%0d credit=%0d", coin_reject, credit);
    chk("ceil.reject", 32'(coin_reject), 1);
    chk("ceil.hold", 32'(credit), 200);
    cyc(1, 2'b00, 1, 0, 0);
    chk("collide.state", 32'(state), 2);
    chk("collide.reject", 32'(coin_reject), 1);
    idle(1);
    chk("collide.credit", 32'(credit), 125);
    cyc(0, 2'b00, 0, 0, 1);
    count_pulses(30, n);
    chk("ceil.pulses", 32'(n), 25);
    chk("ceil.idle", 32'(state), 0);

    // 5: dispenser timeout
    repeat (3) cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    idle(1);
    n3 = (state == 3'd3) ? 1 : 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin
      idle(1);
      if (state == 3'd3) n3++;
    end
    $display("[TB] timeout: dispense_cycles=%0d fault=%0d credit=%0d", n3, fault, credit);
    chk("tmo.cycles", 32'(n3), 15);
    chk("tmo.fault", 32'(fault), 1);
    chk("tmo.state", 32'(state), 4);
    chk("tmo.credit", 32'(credit), 75);
    chk("tmo.req", 32'(disp_req), 0);
    count_pulses(20, n);
    chk("tmo.pulses", 32'(n), 15);
    chk("tmo.idle", 32'(state), 0);

    // 6: reset in CHANGE and in DISPENSE
    cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 0, 1, 0);
    idle(2);
    chk("rstchg.credit_mid", 32'(credit), 15);
    rst = 0; idle(1); rst = 1;
    chk("rstchg.state", 32'(state), 0);
    chk("rstchg.credit", 32'(credit), 0);
    chk("rstchg.pulse", 32'(change_pulse), 0);
    repeat (3) cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    idle(1);
    chk("rstdisp.req_before", 32'(disp_req), 1);
    rst = 0; idle(1); rst = 1;
    $display("[TB] reset in dispense: disp_req=%0d state=%0d", disp_req, state);
    chk("rstdisp.req", 32'(disp_req), 0);
    chk("rstdisp.state", 32'(state), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Top-level sequencing controller for the digital vending machine. Accumulates coin credit and decides purchase versus refund. Drives a req/ack handshake to the item dispenser and pays change back one 5-cent unit per cycle. Extends the 3-state coin FSM (IDLE/ACCEPT/check) into the full purchase flow.

Parameters:
PRICE, 75, item price in cents; must be a multiple of 5.
MAX_CREDIT, 200, credit ceiling in cents; must be a multiple of 5 and >= PRICE.
CREDIT_W, 8, width of the credit register; must hold MAX_CREDIT + 25.
DISP_TIMEOUT, 15, number of DISPENSE cycles without disp_ack before a refund.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  reset, synchronous, active-low (rst=0 at a rising edge resets).
coin  in  1  single-cycle coin-inserted strobe.
coin_val  in  2  coin value: 00=5, 01=10, 10=25, 11=invalid.
select  in  1  purchase request strobe.
cancel  in  1  refund request strobe.
disp_ack  in  1  dispenser acknowledge.
disp_req  out  1  dispense request; level signal.
change_pulse  out  1  one 5-cent coin returned this cycle.
coin_reject  out  1  single-cycle pulse: coin refused.
fault  out  1  single-cycle pulse: dispense timeout.
credit  out  CREDIT_W  current credit in cents.
state  out  3  IDLE=0, ACCEPT=1, CHECK=2, DISPENSE=3, CHANGE=4.

Behaviour:
- All outputs are registered. Reset: state=0, credit=0, disp_req=0, change_pulse=0, coin_reject=0, fault=0, timeout counter=0. Reset overrides every other input, including mid-DISPENSE and mid-CHANGE; credit in flight is discarded.
- Inputs are sampled at edge N; the results are visible after edge N (1-cycle latency).
- Coin acceptance, in IDLE and ACCEPT only:
  - Accept when coin_val != 11 and credit + value <= MAX_CREDIT. Then credit += value, and IDLE moves to ACCEPT.
  - Otherwise pulse coin_reject for 1 cycle; credit and state are unchanged.
  - A coin arriving in CHECK, DISPENSE or CHANGE is always rejected.
- IDLE: select and cancel are ignored.
- ACCEPT: priority is cancel > select > coin.
  - cancel: go to CHANGE.
  - select: go to CHECK; a coin in the same cycle is rejected.
- CHECK: lasts exactly 1 cycle.
  - If credit >= PRICE: credit -= PRICE, go to DISPENSE.
  - Else go back to ACCEPT with credit unchanged.
- DISPENSE:
  - disp_req is 1 for every cycle state=3.
  - disp_ack sampled 1: disp_req goes 0 next cycle; go to CHANGE if credit > 0, else IDLE.
  - The timeout counter increments each DISPENSE cycle without ack. When it reaches DISP_TIMEOUT: credit += PRICE, fault pulses for 1 cycle, go to CHANGE, and the counter clears.
  - If ack arrives on the timeout cycle, ack wins.
- CHANGE:
  - Each cycle with credit >= 5: change_pulse=1 and credit -= 5.
  - The cycle after credit reaches 0: go to IDLE with change_pulse=0.
  - select, cancel and coins are ignored (coins are rejected).
- disp_ack outside DISPENSE is ignored.
- Credit is always a multiple of 5, never exceeds MAX_CREDIT, and never underflows.
- state values 5–7 are unreachable; if entered, recover to IDLE next cycle with credit=0.

Test Plan:
1. Reset/exact pay: rst=0 for 2 cycles → state=0, credit=0. Insert 3×25 → credit=75, state=1. Pulse select → state=2, then state=3 with credit=0, disp_req=1. Assert disp_ack 3 cycles later → disp_req=0, state=0, zero change_pulse.
2. Overpay: 4×25 then select → DISPENSE with credit=25. Ack → exactly 5 consecutive change_pulse cycles, then credit=0, state=0.
3. Short/cancel/invalid:
   - 10+25, select → CHECK then ACCEPT, credit=35.
   - cancel → 7 change_pulse cycles, then IDLE.
   - coin_val=11 in IDLE → coin_reject=1 for 1 cycle, credit=0, state=0.
4. Ceiling: 8×25 → credit=200. A 9th coin → coin_reject=1, credit stays 200. Coin and select in the same cycle → CHECK, coin rejected.
5. Timeout: 75 then select, disp_ack held 0 → after 15 DISPENSE cycles fault=1 for 1 cycle, state=4, credit=75, then 15 change_pulses, then IDLE.
6. Mid-operation reset: reset asserted after 2 change_pulses in CHANGE → next cycle state=0, credit=0, change_pulse=0. Also assert reset during DISPENSE → disp_req=0 next cycle.
